seq_detect_param: RTL and testbench

- Parametrised serial bit-pattern detector. Generalises the fixed four-bit Mealy detector to any pattern length, a runtime-loadable pattern, a data-valid qualifier, three match modes (overlapping, non-overlapping, latching), and a saturating hit counter.
- Sits on a one-bit serial stream beside other serial-protocol blocks. Its `match` output is Mealy: it is asserted in the same cycle as the completing bit.

---
 rtl/seq_detect_param.sv | 98 +++++++++
 tb/tb_seq_detect_param.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector.
// Mealy `match` output. Supports a pattern that can be loaded at run time, a
// data-valid qualifier, overlapping, non-overlapping and latching match modes,
// and a saturating hit counter.
module seq_detect_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1001,
  parameter int             CW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           data,
  input  logic [1:0]     mode,
  input  logic           clear,
  input  logic           pattern_load,
  input  logic [LEN-1:0] pattern_in,
  output logic           match,
  output logic           locked,
  output logic [CW-1:0]  hit_count
);

  localparam int             FW        = $clog2(LEN);
  localparam logic [FW-1:0]  FILL_FULL = FW'(LEN - 1);
  localparam logic [CW-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_OVERLAP    = 2'b00,
    MODE_NONOVERLAP = 2'b01,
    MODE_LATCH      = 2'b10,
    MODE_RESERVED   = 2'b11
  } mode_e;

  logic [LEN-2:0] hist;      // previously accepted bits, newest in the LSB
  logic [FW-1:0]  fill;      // number of valid bits held in hist
  logic [LEN-1:0] pat;       // active pattern, MSB is the first bit received
  logic [LEN-1:0] window;    // candidate pattern formed with the incoming bit
  logic           raw;
  logic [CW-1:0]  cnt_inc;
  mode_e          eff_mode;

  // The reserved mode code behaves exactly like overlapping mode.
  assign eff_mode = (mode == MODE_RESERVED) ? MODE_OVERLAP : mode_e'(mode);

  assign window  = {hist, data};
  assign raw     = en & (fill == FILL_FULL) & (window == pat);
  assign cnt_inc = (hit_count == CNT_MAX) ? hit_count : hit_count + CW'(1);

  // A match in a clear or pattern-load cycle is suppressed because that cycle
  // discards the stream instead of consuming it.
  assign match = ~reset & ~clear & (locked | (raw & ~pattern_load));

  // Shift history, track fill level, and update the latch flag and hit counter.
  // NOTE: all state here uses non-blocking assignments, so each branch reads the
  // pre-edge values of hist/fill/locked/hit_count no matter the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= PATTERN;
      locked    <= 1'b0;
      hit_count <= '0;
    end else if (clear) begin
      hist      <= '0;
      fill      <= '0;
      locked    <= 1'b0;
      hit_count <= '0;
    end else if (pattern_load) begin
      pat  <= pattern_in;
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      if (raw && eff_mode == MODE_NONOVERLAP) begin
        // The next match in this mode must be built from LEN fresh bits.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window[LEN-2:0];
        if (fill != FILL_FULL) begin
          fill <= fill + FW'(1);
        end
      end

      if (raw) begin
        if (eff_mode == MODE_LATCH) begin
          // In latching mode only the first match is counted.
          if (!locked) begin
            locked    <= 1'b1;
            hit_count <= cnt_inc;
          end
        end else begin
          hit_count <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. Two instances share the same
// stimulus: one has an 8-bit counter, and the other has a 2-bit counter to exercise
// saturation. A queue-based reference model predicts every output.
module tb_seq_detect_param;

  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       data;
  logic [1:0] mode;
  logic       clear;
  logic       pattern_load;
  logic [3:0] pattern_in;

  logic       match_a, locked_a, match_b, locked_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.LEN(4), .PATTERN(4'b1001), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .data(data), .mode(mode), .clear(clear),
    .pattern_load(pattern_load), .pattern_in(pattern_in),
    .match(match_a), .locked(locked_a), .hit_count(cnt_a)
  );

  seq_detect_param #(.LEN(4), .PATTERN(4'b1001), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .data(data), .mode(mode), .clear(clear),
    .pattern_load(pattern_load), .pattern_in(pattern_in),
    .match(match_b), .locked(locked_b), .hit_count(cnt_b)
  );

  // ---------------- reference model ----------------
  int         hist_q[$];   // accepted bits since the last flush, oldest first
  logic [3:0] m_pat;
  bit         m_locked;
  int         m_cnt_a, m_cnt_b;

  task automatic model_reset();
    hist_q.delete();
    m_pat    = 4'b1001;
    m_locked = 1'b0;
    m_cnt_a  = 0;
    m_cnt_b  = 0;
  endtask

  function automatic bit model_raw(bit e, bit d);
    if (!e || hist_q.size() < LEN - 1) return 1'b0;
    for (int k = 0; k < LEN - 1; k++)
      if (hist_q[hist_q.size() - (LEN - 1) + k] != int'(m_pat[LEN-1-k])) return 1'b0;
    return d == m_pat[0];
  endfunction

  function automatic bit model_match(bit e, bit d, bit clr, bit pl);
    if (clr) return 1'b0;
    return m_locked | (model_raw(e, d) & !pl);
  endfunction

  task automatic model_update(bit e, bit d, logic [1:0] md, bit clr, bit pl, logic [3:0] pin);
    int eff;
    bit r;
    eff = (md == 2'b11) ? 0 : int'(md);
    r   = model_raw(e, d);
    if (clr) begin
      hist_q.delete();
      m_locked = 1'b0;
      m_cnt_a  = 0;
      m_cnt_b  = 0;
    end else if (pl) begin
      m_pat = pin;
      hist_q.delete();
    end else if (e) begin
      if (r && eff == 1) hist_q.delete();
      else begin
        hist_q.push_back(int'(d));
        if (hist_q.size() > LEN - 1) void'(hist_q.pop_front());
      end
      if (r && !(eff == 2 && m_locked)) begin
        if (eff == 2) m_locked = 1'b1;
        m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
        m_cnt_b = (m_cnt_b < 3)   ? m_cnt_b + 1 : 3;
      end
    end
  endtask

  // ---------------- stimulus driver ----------------
  bit   exp_match;   // model prediction for the cycle just driven
  logic s_ma, s_mb;  // DUT match outputs sampled mid-cycle

  // Drive one cycle after the falling edge, sample the Mealy outputs, then let the
  // rising edge happen and advance the model. Returns 1 time unit after the edge.
  task automatic step(input bit e, input bit d, input logic [1:0] md,
                      input bit clr, input bit pl, input logic [3:0] pin);
    @(negedge clk);
    en = e; data = d; mode = md; clear = clr; pattern_load = pl; pattern_in = pin;
    #1;
    exp_match = model_match(e, d, clr, pl);
    s_ma = match_a;
    s_mb = match_b;
    @(posedge clk);
    model_update(e, d, md, clr, pl, pin);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; en = 1'b1; data = 1'b1; mode = 2'b00; clear = 1'b0;
    pattern_load = 1'b0; pattern_in = 4'h0;
    #12;
    n_tests++;
    if ({match_a, match_b, locked_a, locked_b} !== 4'b0000 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got match=%b%b locked=%b%b cnt_a=%0d cnt_b=%0d, expected all zero",
               match_a, match_b, locked_a, locked_b, cnt_a, cnt_b);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_overlap();
    logic [6:0] s   = 7'b1001001;
    logic [6:0] exp = 7'b0001001;
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[6-i], 2'b00, 1'b0, 1'b0, 4'h0);
      n_tests++;
      if (s_ma !== exp[6-i] || s_mb !== exp[6-i] || exp_match !== exp[6-i]) begin
        n_fail++;
        $display("FAIL overlap_match bit%0d got a=%b b=%b model=%b, expected %b",
                 i + 1, s_ma, s_mb, exp_match, exp[6-i]);
      end
    end
    n_tests++;
    if (cnt_a !== 8'd2 || cnt_b !== 2'd2) begin
      n_fail++;
      $display("FAIL overlap_count got a=%0d b=%0d, expected 2", cnt_a, cnt_b);
    end
  endtask

  task automatic test_nonoverlap();
    logic [10:0] s   = 11'b10010011001;
    logic [10:0] exp = 11'b00010000001;
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, s[10-i], 2'b01, 1'b0, 1'b0, 4'h0);
      n_tests++;
      if (s_ma !== exp[10-i] || s_mb !== exp[10-i] || exp_match !== exp[10-i]) begin
        n_fail++;
        $display("FAIL nonoverlap_match bit%0d got a=%b b=%b model=%b, expected %b",
                 i + 1, s_ma, s_mb, exp_match, exp[10-i]);
      end
      if (i == 6) begin
        n_tests++;
        if (cnt_a !== 8'd1) begin
          n_fail++;
          $display("FAIL nonoverlap_count_mid got %0d, expected 1", cnt_a);
        end
      end
    end
    n_tests++;
    if (cnt_a !== 8'd2 || cnt_b !== 2'd2) begin
      n_fail++;
      $display("FAIL nonoverlap_count got a=%0d b=%0d, expected 2", cnt_a, cnt_b);
    end
  endtask

  task automatic test_latching();
    logic [3:0] s = 4'b1001;
    bit         b;
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 14; i++) begin
      b = (i < 4) ? s[3-i] : 1'($urandom_range(0, 1));
      step(1'b1, b, 2'b10, 1'b0, 1'b0, 4'h0);
      n_tests++;
      if (s_ma !== (i >= 3) || s_mb !== (i >= 3) || locked_a !== (i >= 3) || locked_b !== (i >= 3)) begin
        n_fail++;
        $display("FAIL latch_bit%0d got match=%b%b locked=%b%b, expected match=%b locked=%b",
                 i + 1, s_ma, s_mb, locked_a, locked_b, (i >= 3), (i >= 3));
      end
    end
    n_tests++;
    if (cnt_a !== 8'd1 || cnt_b !== 2'd1) begin
      n_fail++;
      $display("FAIL latch_count got a=%0d b=%0d, expected 1", cnt_a, cnt_b);
    end
    step(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'h0);
    n_tests++;
    if (s_ma !== 1'b0 || locked_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL latch_clear got match=%b locked=%b cnt_a=%0d cnt_b=%0d, expected 0 0 0 0",
               s_ma, locked_a, cnt_a, cnt_b);
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] s = 4'b1001;
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s[3-i], 2'b00, 1'b0, 1'b0, 4'h0);
      n_tests++;
      if (s_ma !== (i == 3) || exp_match !== (i == 3)) begin
        n_fail++;
        $display("FAIL bubble_valid bit%0d got %b model=%b, expected %b", i + 1, s_ma, exp_match, (i == 3));
      end
      for (int j = 0; j < 2; j++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b0, 4'h0);
        n_tests++;
        if (s_ma !== 1'b0 || s_mb !== 1'b0) begin
          n_fail++;
          $display("FAIL bubble_idle after bit%0d got %b%b, expected 0", i + 1, s_ma, s_mb);
        end
      end
    end
    n_tests++;
    if (cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL bubble_count got %0d, expected 1", cnt_a);
    end
  endtask

  task automatic test_load();
    logic [7:0] s   = 8'b01101001;
    logic [7:0] exp = 8'b00010000;
    logic [2:0] pre = 3'b011;
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 4'b0110);
    n_tests++;
    if (s_ma !== 1'b0 || cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL load_cycle got match=%b cnt=%0d, expected 0 and 1", s_ma, cnt_a);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[7-i], 2'b00, 1'b0, 1'b0, 4'h0);
      n_tests++;
      if (s_ma !== exp[7-i] || exp_match !== exp[7-i]) begin
        n_fail++;
        $display("FAIL load_match bit%0d got %b model=%b, expected %b", i + 1, s_ma, exp_match, exp[7-i]);
      end
    end
    // Complete 0110 in the very cycle the pattern is reloaded: no match, no count.
    for (int i = 0; i < 3; i++) step(1'b1, pre[2-i], 2'b00, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 4'b1001);
    n_tests++;
    if (s_ma !== 1'b0 || cnt_a !== 8'd2) begin
      n_fail++;
      $display("FAIL load_suppress got match=%b cnt=%0d, expected 0 and 2", s_ma, cnt_a);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] s = 4'b1001;
    int pulses = 0;
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, s[3 - (i % 4)], 2'b00, 1'b0, 1'b0, 4'h0);
      if (s_mb === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 5 || cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
      n_fail++;
      $display("FAIL saturation got pulses=%0d cnt_b=%0d cnt_a=%0d, expected 5 3 5", pulses, cnt_b, cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s = 7'b1001100;
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) step(1'b1, s[6-i], 2'b10, 1'b0, 1'b0, 4'h0);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({match_a, match_b, locked_a, locked_b} !== 4'b0000 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async got match=%b%b locked=%b%b cnt_a=%0d cnt_b=%0d, expected all zero",
               match_a, match_b, locked_a, locked_b, cnt_a, cnt_b);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
    n_tests++;
    if (s_ma !== 1'b0 || s_mb !== 1'b0 || exp_match !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_spurious got %b%b model=%b, expected 0", s_ma, s_mb, exp_match);
    end
  endtask

  task automatic test_random();
    bit         e, d, clr, pl;
    logic [1:0] md;
    logic [3:0] pin;
    for (int c = 0; c < 400; c++) begin
      e   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      md  = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 24) == 0);
      pl  = ($urandom_range(0, 29) == 0);
      pin = ($urandom_range(0, 1) == 0) ? 4'b1001 : 4'($urandom);
      step(e, d, md, clr, pl, pin);
      n_tests++;
      if (s_ma !== exp_match || s_mb !== exp_match) begin
        n_fail++;
        $display("FAIL rand_match cyc=%0d got a=%b b=%b, expected %b", c, s_ma, s_mb, exp_match);
      end
      n_tests++;
      if (locked_a !== m_locked || locked_b !== m_locked ||
          cnt_a !== 8'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d got locked=%b%b cnt_a=%0d cnt_b=%0d, expected locked=%b cnt_a=%0d cnt_b=%0d",
                 c, locked_a, locked_b, cnt_a, cnt_b, m_locked, m_cnt_a, m_cnt_b);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_latching();
    test_bubbles();
    test_load();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
